mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the OTTER IOBUS. It is the responder to the CPU's IOBUS write initiator.
- Firmware stores bytes to a data address. The bytes are queued in a small FIFO and serialised LSB-first on a TX pin (8N1).
- Gives the MCU a serial output path toward the same host link used by the serial programmer.
- Status (busy/full/empty/overflow) is exported as a 32-bit word for the top-level IOBUS_IN read mux.

---
 rtl/mmio_uart_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: IOBUS-mapped UART transmitter (byte FIFO, 8N1, status word)
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between data and stop)
module mmio_uart_tx #(
  parameter int CLK_RATE = 50,
  parameter int BAUD = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h11000100,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] STATUS,
  output logic        TX
);
  localparam int DIV = (CLK_RATE * 1000000 + BAUD / 2) / BAUD;
  localparam int CW = $clog2(DIV + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift, shift_n;
  logic ovf, empty, full, push_req, clr, pop, push, tick, tx_n, unused_hi;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign push_req = IOBUS_WR && IOBUS_ADDR == BASE_ADDR;
  assign clr = IOBUS_WR && IOBUS_ADDR == BASE_ADDR + 32'd4 && IOBUS_OUT[0];
  assign push = push_req && (!full || pop);
  assign tick = cnt == CW'(DIV - 1);
  assign STATUS = {28'b0, ovf, full, empty, state != IDLE};
  assign unused_hi = ^IOBUS_OUT[31:8];
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      START: state_n = tick ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA: state_n = (tick && idx == 3'd7) ? PARITY : DATA;
      PARITY: state_n = tick ? STOP : PARITY;
`else
      DATA: state_n = (tick && idx == 3'd7) ? STOP : DATA;
`endif
      STOP: begin
        pop = tick && !empty;
        state_n = !tick ? STOP : empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    shift_n = pop ? mem[rp[AW-1:0]] : (state == DATA && tick) ? shift >> 1 : shift;
    // TX is registered from the next state so the pin never glitches
    tx_n = state_n != START && (state_n != DATA || shift_n[0]);
`ifdef UART_TX_PARITY_EN
    if (state_n == PARITY) tx_n = par;
`endif
  end
  always_ff @(posedge CLK)
    if (push) mem[wp[AW-1:0]] <= IOBUS_OUT[7:0];
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      ovf <= 1'b0;
      TX <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      idx <= state != DATA ? '0 : tick ? idx + 1'b1 : idx;
      shift <= shift_n;
      ovf <= !clr && (ovf || (push_req && full && !pop));
      TX <= tx_n;
`ifdef UART_TX_PARITY_EN
      par <= pop ? ^mem[rp[AW-1:0]] : par;
`endif
    end
endmodule
